// File: rtl/button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// button_debounce_pulse
//
// Purpose:
//   Conditions a raw, asynchronous, bouncy push-button into a clean debounced
//   level plus single-cycle press/release strobes. press_pulse is intended to
//   drive the enable of a downstream counter, so that the counter advances
//   exactly once per physical press.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   button_in      in   raw button (asynchronous, bouncy), 1 = pressed
//   button_level   out  debounced level (registered)
//   press_pulse    out  1-cycle strobe on an accepted 0->1 (registered)
//   release_pulse  out  1-cycle strobe on an accepted 1->0 (registered)
//   busy           out  high while a new value is being qualified (registered)
//
// Parameters:
//   SYNC_STAGES      synchronizer depth on button_in (>= 2)
//   DEBOUNCE_CYCLES  consecutive samples of a new value needed to accept it (>= 2)
// -----------------------------------------------------------------------------
module button_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer chain: stage 0 samples the pin, the last stage is btn_s.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   btn_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = button_in;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign btn_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM state, stability counter and registered outputs.
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    // cnt counts how many consecutive samples of the candidate value have
    // been seen; entering a WAIT state already accounts for the first one,
    // so acceptance happens when the DEBOUNCE_CYCLES-th sample arrives.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            STABLE_LOW: begin
                if (btn_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    // Opposite sample: drop the candidate, no pulse.
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!btn_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LOW;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered copies of next-state decodes so they change
        // on the same edge as the state they describe.
        level_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
        busy_d  = (state_d == WAIT_HIGH)   || (state_d == WAIT_LOW);
    end

    assign button_level  = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_pulse
//
// Directed bench for button_debounce_pulse with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Expected output vectors are hand-computed and packed as
// {button_level, press_pulse, release_pulse, busy}. A small negedge monitor
// plays the role of the downstream counter fed by press_pulse.
// -----------------------------------------------------------------------------
module tb_button_debounce_pulse;

    logic clk = 1'b0;
    logic reset;
    logic button_in;
    logic button_level;
    logic press_pulse;
    logic release_pulse;
    logic busy;

    int n_vec  = 0;
    int n_miss = 0;

    int press_cnt   = 0;   // models the downstream counter enabled by press_pulse
    int release_cnt = 0;
    int both_high   = 0;

    button_debounce_pulse #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .button_level (button_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse)                  press_cnt++;
        if (release_pulse)                release_cnt++;
        if (press_pulse && release_pulse) both_high++;
    end

    function automatic logic [3:0] outs();
        return {button_level, press_pulse, release_pulse, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response to a clean edge, edges 0..6 after the input change.
    logic [3:0] exp_press   [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    logic [3:0] exp_release [7] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000};
    // 3-sample low glitch while high: qualification restarts, no release.
    logic [3:0] exp_glitch  [8] = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000};
    // Bounce 1,0,1,1,0 then steady 1.
    logic       bounce_in   [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_bounce  [12] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001,
                                     4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};

    initial begin
        int p0, r0;

        // 1. Reset, then quiet idle.
        reset     = 1'b1;
        button_in = 1'b0;
        repeat (3) tick();
        check("reset_outs", 32'(outs()), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_%0d", i), 32'(outs()), 32'h0);
        end

        // 2. Clean press, held.
        button_in = 1'b1;
        for (int e = 0; e < 7; e++) begin
            tick();
            check($sformatf("press_e%0d", e), 32'(outs()), 32'(exp_press[e]));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("held_%0d", i), 32'(outs()), 32'b1000);
        end

        // 4a. Clean release.
        button_in = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            check($sformatf("release_e%0d", e), 32'(outs()), 32'(exp_release[e]));
        end

        // 4b. Press again, then a 3-cycle low glitch.
        button_in = 1'b1;
        repeat (8) tick();
        check("repress_level", 32'(outs()), 32'b1000);
        r0 = release_cnt;
        for (int e = 0; e < 8; e++) begin
            button_in = (e < 3) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("glitch_e%0d", e), 32'(outs()), 32'(exp_glitch[e]));
        end
        check("glitch_no_release", 32'(release_cnt - r0), 32'd0);
        button_in = 1'b0;
        repeat (8) tick();
        check("after_glitch_release", 32'(outs()), 32'b0000);

        // 3. Bounce then steady high.
        p0 = press_cnt;
        for (int e = 0; e < 12; e++) begin
            button_in = bounce_in[e];
            tick();
            check($sformatf("bounce_e%0d", e), 32'(outs()), 32'(exp_bounce[e]));
        end
        check("bounce_one_press", 32'(press_cnt - p0), 32'd1);
        button_in = 1'b0;
        repeat (8) tick();
        check("bounce_released", 32'(outs()), 32'b0000);

        // 5. Reset mid-WAIT_HIGH (cnt=2 after edge 3).
        p0 = press_cnt;
        button_in = 1'b1;
        repeat (4) tick();
        check("abort_busy", 32'(outs()), 32'b0001);
        reset     = 1'b1;
        button_in = 1'b0;
        tick();
        check("abort_reset_outs", 32'(outs()), 32'b0000);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("abort_idle_%0d", i), 32'(outs()), 32'b0000);
        end
        check("abort_no_press", 32'(press_cnt - p0), 32'd0);

        // Button held through reset deassertion qualifies normally.
        reset     = 1'b1;
        button_in = 1'b1;
        repeat (3) tick();
        check("held_reset_outs", 32'(outs()), 32'b0000);
        reset = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            check($sformatf("held_rst_e%0d", e), 32'(outs()), 32'(exp_press[e]));
        end
        button_in = 1'b0;
        repeat (8) tick();

        // 6. Ten clean presses into the counter model.
        p0 = press_cnt;
        r0 = release_cnt;
        for (int k = 0; k < 10; k++) begin
            button_in = 1'b1;
            repeat (10) tick();
            button_in = 1'b0;
            repeat (10) tick();
        end
        check("counter_10_presses", 32'(press_cnt - p0), 32'd10);
        check("counter_10_releases", 32'(release_cnt - r0), 32'd10);
        check("never_both_pulses", 32'(both_high), 32'd0);
        check("total_presses", 32'(press_cnt), 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Safety net so a stuck run still terminates with a report.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
